branch_predictor_bank: RTL and testbench

//  Synthesizable, parametrised successor to the DPI predictor harness.

---
 rtl/bp_pkg.sv | 24 ++
 rtl/bp_update_fifo.sv | 61 ++++++
 rtl/branch_predictor_bank.sv | 167 ++++++++++++++++
 tb/tb_branch_predictor_bank.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and counter arithmetic for the branch predictor bank.
package bp_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_WEAK_NT = 2'b01;

    typedef enum logic {
        BP_INIT = 1'b0,
        BP_RUN  = 1'b1
    } bp_state_e;

    function automatic ctr_t ctr_sat_update(input ctr_t ctr, input logic taken);
        ctr_t res;
        res = ctr;
        if (taken && (ctr != 2'b11)) begin
            res = ctr + 2'd1;
        end else if (!taken && (ctr != 2'b00)) begin
            res = ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// Synchronous FIFO buffering commit-order {pc, taken} training updates.
module bp_update_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 65
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is dropped even if a pop frees a slot this cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/branch_predictor_bank.sv
// Multi-lane 2-bit-counter branch predictor with buffered commit-order training.
// Define BP_GHIST_EN to hash indices with a global history register (gshare).
//
// state   | meaning
// BP_INIT | writing CTR_WEAK_NT to every entry, one per cycle
// BP_RUN  | serving predictions and applying buffered updates
module branch_predictor_bank
    import bp_pkg::*;
#(
    parameter int NUM_LANES      = 4,
    parameter int TABLE_DEPTH    = 1024,
    parameter int PC_W           = 64,
    parameter int INST_SHIFT     = 1,
    parameter int UPD_FIFO_DEPTH = 4,
    parameter int HIST_W         = 8
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [PC_W-1:0]      req_pc_i,
    output logic                 resp_valid_o,
    output logic [NUM_LANES-1:0] resp_taken_o,
    input  logic                 update_valid_i,
    output logic                 update_ready_o,
    input  logic [PC_W-1:0]      update_pc_i,
    input  logic                 update_taken_i
);
    localparam int IDX_W  = $clog2(TABLE_DEPTH);
    localparam int FIFO_W = PC_W + 1;

    if ((TABLE_DEPTH != (1 << IDX_W)) || (UPD_FIFO_DEPTH < 2) || (HIST_W > IDX_W)) begin : g_bad_params
        $error("branch_predictor_bank: illegal parameter combination");
    end

    bp_state_e          state_q, state_d;
    logic [IDX_W-1:0]   init_ptr_q, init_ptr_d;
    ctr_t               ctr_q [TABLE_DEPTH];

    logic               resp_valid_q, resp_valid_d;
    logic [NUM_LANES-1:0] resp_taken_q, resp_taken_d;

    logic               accept;
    logic               upd_push, upd_pop;
    logic               fifo_full, fifo_empty;
    logic [FIFO_W-1:0]  fifo_rd;
    logic [PC_W-1:0]    deq_pc;
    logic               deq_taken;
    logic [IDX_W-1:0]   hist_idx;
    logic [IDX_W-1:0]   deq_idx;
    logic [IDX_W-1:0]   lane_idx [NUM_LANES];
    logic [NUM_LANES-1:0] lane_taken;

    logic               tbl_we;
    logic [IDX_W-1:0]   tbl_widx;
    ctr_t               tbl_wdata;

    always_comb begin
        state_d     = state_q;
        init_ptr_d  = init_ptr_q;
        req_ready_o = 1'b0;
        case (state_q)
            BP_INIT: begin
                init_ptr_d = init_ptr_q + IDX_W'(1);
                if (init_ptr_q == IDX_W'(TABLE_DEPTH - 1)) state_d = BP_RUN;
            end
            BP_RUN: begin
                req_ready_o = 1'b1;
            end
            default: state_d = BP_INIT;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= BP_INIT;
            init_ptr_q <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
        end
    end

    assign accept         = req_valid_i && req_ready_o;
    assign update_ready_o = !fifo_full && (state_q == BP_RUN);
    assign upd_push       = update_valid_i && update_ready_o;
    assign upd_pop        = !fifo_empty && (state_q == BP_RUN);

    bp_update_fifo #(
        .DEPTH (UPD_FIFO_DEPTH),
        .W     (FIFO_W)
    ) u_upd_fifo (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .push_i  (upd_push),
        .data_i  ({update_pc_i, update_taken_i}),
        .pop_i   (upd_pop),
        .data_o  (fifo_rd),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign deq_pc    = fifo_rd[FIFO_W-1:1];
    assign deq_taken = fifo_rd[0];

`ifdef BP_GHIST_EN
    logic [HIST_W-1:0] ghist_q, ghist_d;

    assign ghist_d  = upd_pop ? {ghist_q[HIST_W-2:0], deq_taken} : ghist_q;
    assign hist_idx = IDX_W'(ghist_q);

    always_ff @(posedge clock_i) begin
        if (reset_i) ghist_q <= '0;
        else         ghist_q <= ghist_d;
    end
`else
    assign hist_idx = '0;
`endif

    // Lane offsets only touch bits at and above INST_SHIFT, so the lane index is
    // the base index plus the lane number, wrapping modulo TABLE_DEPTH.
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign lane_idx[g]   = (req_pc_i[INST_SHIFT +: IDX_W] + IDX_W'(g)) ^ hist_idx;
        assign lane_taken[g] = ctr_q[lane_idx[g]][1];
    end

    assign deq_idx = deq_pc[INST_SHIFT +: IDX_W] ^ hist_idx;

    always_comb begin
        tbl_we    = 1'b0;
        tbl_widx  = init_ptr_q;
        tbl_wdata = CTR_WEAK_NT;
        if (state_q == BP_INIT) begin
            tbl_we = 1'b1;
        end else if (upd_pop) begin
            tbl_we    = 1'b1;
            tbl_widx  = deq_idx;
            tbl_wdata = ctr_sat_update(ctr_q[deq_idx], deq_taken);
        end
    end

    // Reads are combinational from the current array, so a same-cycle
    // prediction observes the counter before this cycle's write lands.
    always_ff @(posedge clock_i) begin
        if (tbl_we) ctr_q[tbl_widx] <= tbl_wdata;
    end

    assign resp_valid_d = accept;
    assign resp_taken_d = accept ? lane_taken : resp_taken_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            resp_valid_q <= 1'b0;
            resp_taken_q <= '0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_taken_q <= resp_taken_d;
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_taken_o = resp_taken_q;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{req_pc_i, deq_pc};

endmodule

// File: tb/tb_branch_predictor_bank.sv
// Directed and random stimulus against a queue/array reference model of the predictor.
`timescale 1ns/1ps
module tb_branch_predictor_bank;

    localparam int LANES = 4;
    localparam int DEPTH = 16;
    localparam int FDEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_pc;
    logic        resp_valid;
    logic [3:0]  resp_taken;
    logic        update_valid;
    logic        update_ready;
    logic [63:0] update_pc;
    logic        update_taken;

    always #5 clock = ~clock;

    branch_predictor_bank #(
        .NUM_LANES      (LANES),
        .TABLE_DEPTH    (DEPTH),
        .PC_W           (64),
        .INST_SHIFT     (1),
        .UPD_FIFO_DEPTH (FDEPTH),
        .HIST_W         (2)
    ) dut (
        .clock_i        (clock),
        .reset_i        (reset),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_pc_i       (req_pc),
        .resp_valid_o   (resp_valid),
        .resp_taken_o   (resp_taken),
        .update_valid_i (update_valid),
        .update_ready_o (update_ready),
        .update_pc_i    (update_pc),
        .update_taken_i (update_taken)
    );

    typedef struct {
        logic [63:0] pc;
        bit          taken;
    } upd_t;

    int unsigned m_ctr [DEPTH];
    int unsigned m_gh;
    upd_t        m_q [$];
    int          m_cycles;
    bit          m_known;
    bit          m_resp_v;
    logic [3:0]  m_resp;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned m_index(input logic [63:0] pc);
        int unsigned base;
        base = int'((pc / 64'd2) % 64'(DEPTH));
`ifdef BP_GHIST_EN
        base = base ^ m_gh;
`endif
        return base;
    endfunction

    function automatic logic [3:0] m_predict(input logic [63:0] pc);
        logic [3:0] r;
        for (int i = 0; i < LANES; i++) begin
            r[i] = (m_ctr[m_index(pc + 64'(2 * i))] >= 2);
        end
        return r;
    endfunction

    // One clock cycle: drive, check the handshake outputs, advance the model, then check the response.
    task automatic step(input bit rst, input bit rv, input logic [63:0] pc,
                        input bit uv, input logic [63:0] upc, input bit ut);
        bit   run;
        bit   upd_rdy;
        upd_t e;
        int unsigned ix;
        reset        = rst;
        req_valid    = rv;
        req_pc       = pc;
        update_valid = uv;
        update_pc    = upc;
        update_taken = ut;
        run     = (m_cycles >= DEPTH);
        upd_rdy = run && (m_q.size() < FDEPTH);
        if (m_known) begin
            chk("req_ready", req_ready, run);
            chk("update_ready", update_ready, upd_rdy);
        end
        if (rst) begin
            m_q.delete();
            m_gh     = 0;
            m_cycles = 0;
            m_resp_v = 1'b0;
            m_resp   = 4'b0000;
            m_known  = 1'b1;
            for (int i = 0; i < DEPTH; i++) m_ctr[i] = 1;
        end else begin
            m_resp_v = rv && run;
            if (m_resp_v) m_resp = m_predict(pc);
            if (run && m_q.size() > 0) begin
                e  = m_q.pop_front();
                ix = m_index(e.pc);
                if (e.taken && m_ctr[ix] < 3) m_ctr[ix]++;
                if (!e.taken && m_ctr[ix] > 0) m_ctr[ix]--;
                m_gh = ((m_gh << 1) | int'(e.taken)) & 3;
            end
            if (uv && upd_rdy) m_q.push_back('{pc: upc, taken: ut});
            if (!run) m_cycles++;
        end
        @(posedge clock);
        #1;
        chk("resp_valid", resp_valid, m_resp_v);
        if (m_resp_v || rst) chk("resp_taken", resp_taken, m_resp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 64'h0, 0, 64'h0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 64'h0, 0, 64'h0, 0);
        step(1, 0, 64'h0, 0, 64'h0, 0);
    endtask

    function automatic logic [63:0] rand_pc();
        if ($urandom_range(0, 15) == 0) return 64'hFFFF_FFFF_FFFF_FFF8 + 64'(2 * $urandom_range(0, 3));
        return 64'($urandom_range(0, 47)) * 64'd2;
    endfunction

    initial begin
        m_known = 1'b0;
        m_cycles = 0;
        m_gh = 0;
        reset = 1'b1;
        req_valid = 1'b0;
        req_pc = '0;
        update_valid = 1'b0;
        update_pc = '0;
        update_taken = 1'b0;

        // Reset and INIT length, then first prediction of all weak-not-taken.
        do_reset();
        idle(DEPTH);
        step(0, 1, 64'h0, 0, 64'h0, 0);
        chk("first_resp", resp_taken, 4'b0000);

        // Three taken updates to pc 0x8, then predict it.
        step(0, 0, 64'h0, 1, 64'h8, 1);
        step(0, 0, 64'h0, 1, 64'h8, 1);
        step(0, 0, 64'h0, 1, 64'h8, 1);
        idle(2);
        step(0, 1, 64'h8, 0, 64'h0, 0);
`ifndef BP_GHIST_EN
        chk("train_pc8", resp_taken, 4'b0001);
`endif

        // Back-to-back enqueues; every update must land in order.
        for (int i = 0; i < 6; i++) step(0, 0, 64'h0, 1, 64'h20 + 64'(2 * (i % 3)), (i % 2) == 0);
        idle(3);
        step(0, 1, 64'h20, 0, 64'h0, 0);

        // Same-cycle update and predict on one entry: old value, then new.
        step(0, 0, 64'h0, 1, 64'h30, 1);
        step(0, 1, 64'h30, 0, 64'h0, 0);
        step(0, 1, 64'h30, 0, 64'h0, 0);

        // Predictions whose lanes wrap around the PC space.
        step(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, 0);
        step(0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 1, 64'h0, 1);
        idle(1);

        // Reset with updates buffered and a response pending.
        step(0, 0, 64'h0, 1, 64'h8, 0);
        step(0, 1, 64'h8, 1, 64'h8, 0);
        step(1, 0, 64'h0, 0, 64'h0, 0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        idle(DEPTH);
        for (int i = 0; i < DEPTH / LANES; i++) begin
            step(0, 1, 64'(i * 2 * LANES), 0, 64'h0, 0);
            chk("reinit_ctr", resp_taken, 4'b0000);
        end

`ifdef BP_GHIST_EN
        do_reset();
        idle(DEPTH);
        step(0, 0, 64'h0, 1, 64'h0, 1);
        step(0, 0, 64'h0, 1, 64'h0, 1);
        idle(2);
        step(0, 1, 64'h0, 0, 64'h0, 0);
        chk("gshare_pc0", resp_taken, 4'b1100);
`endif

        // Random traffic, including one mid-run reset.
        for (int k = 0; k < 400; k++) begin
            if (k == 200) begin
                step(1, 0, 64'h0, 0, 64'h0, 0);
            end else begin
                step(0, $urandom_range(0, 1) == 1, rand_pc(),
                     $urandom_range(0, 9) < 7, rand_pc(), $urandom_range(0, 2) != 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
